load_store_unit: RTL and testbench
==================================

# load_store_unit

Pipeline-side load/store initiator for the RV32I core. It accepts one load or store per handshake from the memory stage and drives a word-wide request/acknowledge data-memory port, generating byte enables and lane-aligned write data. It splits accesses that cross a word boundary into two beats and returns sign- or zero-extended load data. Byte order matches the existing data memory: the lowest-addressed byte is the most significant byte.

## Interface
- TIMEOUT_CYCLES, 16: number of consecutive cycles with MemReq high and no MemAck before a beat is aborted.
- ALLOW_MISALIGNED, 1: when 1, word-crossing accesses are split into two beats; when 0, they are rejected with an error.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- ReqValid  in  1  a request is present.
- ReqReady  out  1  the unit can accept a request; high only in IDLE.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqStrobe  in  3  funct3 encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu. Any other value is treated as w.
- ReqAddr  in  32  byte address.
- ReqWData  in  32  store data, right-justified.
- RespValid  out  1  one-cycle pulse when the access completes.
- RespRData  out  32  extended load data; 0 for stores.
- RespErr  out  1  qualifies RespValid; set on timeout or on a rejected misaligned access.
- MemReq  out  1  memory beat request.
- MemAck  in  1  beat accepted; for a read, MemRData is valid in the same cycle.
- MemWe  out  1  write beat.
- MemAddr  out  32  word-aligned address; bits [1:0] are always 00.
- MemByteEn  out  4  lane enables; bit 3 selects bits [31:24], which hold byte offset 0.
- MemWData  out  32  lane-aligned write data.
- MemRData  in  32  read data.

## Operation
- **States:**
  - IDLE: ReqReady=1.
  - BEAT0, BEAT1: MemReq=1.
  - RESP: RespValid=1, for one cycle, then return to IDLE.
- **Accept:** ReqValid&&ReqReady latches write, strobe, address and data. Next state is BEAT0.
- **Rejected access:** if ALLOW_MISALIGNED=0 and the access crosses a word, go directly to RESP with RespErr=1. No memory beat is issued.
- **Beat decomposition** (byte offset o = addr[1:0], size n = 1/2/4):
  - Beat0: word addr[31:2], lanes o..min(o+n-1, 3).
  - Beat1: exists only if o+n>4. Word addr[31:2]+1 (wraps modulo 2^32), lanes 0..o+n-5.
  - Lane k occupies bits [31-8k:24-8k].
- **Store data:** the store bytes, MSB first, are placed into consecutive enabled lanes across the beats. Bytes are split across beats in address order. Disabled lanes drive 0.
- **Load data:** enabled lanes are captured into a 32-bit merge register on each MemAck and concatenated in address order. The result is sign-extended (b, h) or zero-extended (bu, hu) from bit 8n-1.
- **Beat completion:** MemAck in BEAT0 moves to BEAT1 if a second beat is needed, else to RESP. MemAck in BEAT1 moves to RESP.
- **Timeout:** a per-beat counter is cleared at beat entry and increments while MemAck=0. When it reaches TIMEOUT_CYCLES, drop MemReq, go to RESP with RespErr=1 and RespRData=0. A completed beat0 write is not rolled back.
- **Ignored input:** MemAck outside BEAT0/BEAT1 is ignored.

## Timing
- **Reset values:** ReqReady=1. RespValid, RespErr, RespRData, MemReq, MemWe, MemAddr, MemByteEn and MemWData are all 0. State=IDLE, counter=0.
- **Reset mid-access:** MemReq falls asynchronously. No response is produced. The in-flight request is lost.
- **Mem outputs** are registered and held stable from the assertion of MemReq until the cycle in which MemAck is sampled high.
- **Latency**, with request accepted at cycle 0 and zero-wait acknowledge:
  - Aligned: MemReq in cycle 1, RespValid in cycle 2.
  - Split: MemReq in cycles 1 and 2, RespValid in cycle 3.
  - Each wait cycle adds one cycle.
- **Throughput:** ReqReady is low from cycle 1 through the RESP cycle, so IDLE returns in the cycle after RESP. Maximum rate is one aligned access per 3 cycles.
- **Response data:** RespRData and RespErr are valid only while RespValid=1, and return to 0 afterwards.

## Structure
- **Shared package `rv32i_pkg`:**
  - Strobe encodings: STB_B, STB_H, STB_W, STB_BU, STB_HU.
  - State enum: IDLE, BEAT0, BEAT1, RESP.
- **Sub-module `lsu_lane_align`** (combinational), with these responsibilities:
  - offset/size → per-beat byte enables and beat count;
  - store-data lane placement;
  - load merge and extension.
- **Top level:** the FSM, timeout counter, request registers and merge register.

## Test plan
- **sw, aligned:** sw 0x11223344 to 0x100, zero-wait acknowledge → one beat: MemAddr=0x100, MemByteEn=1111, MemWData=0x11223344. RespValid in cycle 2 with RespErr=0.
- **lb / lbu, one lane:** memory word at 0x104 = 0xA1B2C3D4.
  - lb from 0x106 → RespRData=0xFFFFFFC3.
  - lbu from 0x106 → RespRData=0x000000C3.
  - MemByteEn=0010 in both cases.
- **Split sh:** sh 0xBEEF to 0x103 → beat0 MemAddr=0x100, ByteEn=0001, WData=0x000000BE; beat1 MemAddr=0x104, ByteEn=1000, WData=0xEF000000. RespValid in cycle 3.
- **Split lw with waits:** memory words 0x200=0x01020304 and 0x204=0x05060708; lw from 0x202 with 2 wait cycles on each beat → RespRData=0x03040506, RespValid in cycle 7.
- **Timeout:** MemAck held at 0 with TIMEOUT_CYCLES=16 → MemReq drops after 16 cycles; one RespValid pulse with RespErr=1 and RespRData=0; ReqReady=1 in the following cycle.
- **Reset mid-beat / ALLOW_MISALIGNED=0:**
  - RST low while in BEAT1 → all outputs return to reset values immediately; no RespValid ever appears.
  - ALLOW_MISALIGNED=0, lw from 0x001 → no MemReq; RespErr=1 in cycle 1.

Source files
------------

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared RV32I definitions used by the load/store unit:
//                funct3 strobe encodings, LSU state enum and small helpers.
//  Contents    : STB_* strobe codes, lsu_state_e, strobe_size(), lane_mask()
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam logic [2:0] STB_B  = 3'b000;
    localparam logic [2:0] STB_H  = 3'b001;
    localparam logic [2:0] STB_W  = 3'b010;
    localparam logic [2:0] STB_BU = 3'b100;
    localparam logic [2:0] STB_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Access size in bytes; unknown funct3 codes behave as a word access.
    function automatic logic [2:0] strobe_size(input logic [2:0] strobe);
        case (strobe)
            STB_B, STB_BU: return 3'd1;
            STB_H, STB_HU: return 3'd2;
            STB_W:         return 3'd4;
            default:       return 3'd4;
        endcase
    endfunction

    // Expand 4 lane enables (bit 3 = bits [31:24]) into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane_align
//  Description : Combinational lane logic for the load/store unit. Maps byte
//                offset and size onto per-beat byte enables, places store
//                bytes into lanes and merges/extends load data.
//  Ports       : offset, strobe, store_data      - access description
//                load_w0, load_w1                - beat0 / beat1 read words
//                be0, be1, two_beats             - lane enables, beat count
//                store_w0, store_w1              - lane-aligned write words
//                load_data                       - extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import rv32i_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  strobe,
    input  logic [31:0] store_data,
    input  logic [31:0] load_w0,
    input  logic [31:0] load_w1,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic        two_beats,
    output logic [31:0] store_w0,
    output logic [31:0] store_w1,
    output logic [31:0] load_data
);

    logic [2:0]  size;
    logic [5:0]  pad_bits;   // 8 * (4 - size)
    logic [4:0]  off_bits;   // 8 * offset
    logic [7:0]  be_dw;
    logic [63:0] store_dw;
    logic [31:0] load_raw;
    logic        sign_ext;

    // The two beats are treated as one big-endian 64-bit double word: byte
    // position p of the pair sits at bits [63-8p:56-8p], so beat0 is the
    // upper half and beat1 the lower half.
    always_comb begin
        size     = strobe_size(strobe);
        pad_bits = {3'd4 - size, 3'b000};
        off_bits = {offset, 3'b000};
        sign_ext = ~strobe[2];

        // size ones at the top of the double-word map, moved to the offset
        be_dw    = (8'hF0 << (3'd4 - size)) >> offset;

        // left-justify the right-justified store bytes, then move to offset
        store_dw = ({store_data, 32'h0} << pad_bits) >> off_bits;

        // bring byte o to the top, then right-justify the size bytes
        load_raw = 32'(({load_w0, load_w1} << off_bits) >> (7'd32 + {1'b0, pad_bits}));

        case (size)
            3'd1:    load_data = {{24{sign_ext & load_raw[7]}},  load_raw[7:0]};
            3'd2:    load_data = {{16{sign_ext & load_raw[15]}}, load_raw[15:0]};
            default: load_data = load_raw;
        endcase
    end

    assign be0       = be_dw[7:4];
    assign be1       = be_dw[3:0];
    assign two_beats = |be_dw[3:0];
    assign store_w0  = store_dw[63:32];
    assign store_w1  = store_dw[31:0];

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : RV32I load/store initiator. Accepts one request per
//                handshake, issues one or two word beats on a req/ack data
//                memory port, and returns a one-cycle response.
//  Ports       : CLK, RST (async active-low)
//                ReqValid/ReqReady/ReqWrite/ReqStrobe/ReqAddr/ReqWData
//                RespValid/RespRData/RespErr
//                MemReq/MemAck/MemWe/MemAddr/MemByteEn/MemWData/MemRData
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT_CYCLES   = 16,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [2:0]  ReqStrobe,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RespValid,
    output logic [31:0] RespRData,
    output logic        RespErr,
    output logic        MemReq,
    input  logic        MemAck,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemByteEn,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e        state_q, state_d;
    logic              req_write_q;
    logic [2:0]        req_strobe_q;
    logic [31:0]       req_addr_q, req_wdata_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       merge_q, resp_rdata_q;
    logic              resp_err_q;
    logic              mem_req_q, mem_we_q;
    logic [31:0]       mem_addr_q, mem_wdata_q;
    logic [3:0]        mem_be_q;

    logic [31:0] al_addr, al_wdata, al_w0;
    logic [2:0]  al_strobe;
    logic [3:0]  be0, be1;
    logic        two_beats;
    logic [31:0] store_w0, store_w1, load_data;
    logic        accept, reject, beat_ack, timed_out, in_beat, timeout_hit;

    // In IDLE the lane logic looks at the incoming request so beat0 can be
    // registered at accept time; afterwards it looks at the latched request.
    always_comb begin
        al_addr   = (state_q == IDLE) ? ReqAddr   : req_addr_q;
        al_strobe = (state_q == IDLE) ? ReqStrobe : req_strobe_q;
        al_wdata  = (state_q == IDLE) ? ReqWData  : req_wdata_q;
        al_w0     = (state_q == BEAT1) ? merge_q  : MemRData;
    end

    lsu_lane_align u_align (
        .offset     (al_addr[1:0]),
        .strobe     (al_strobe),
        .store_data (al_wdata),
        .load_w0    (al_w0),
        .load_w1    (MemRData),
        .be0        (be0),
        .be1        (be1),
        .two_beats  (two_beats),
        .store_w0   (store_w0),
        .store_w1   (store_w1),
        .load_data  (load_data)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        reject      = 1'b0;
        beat_ack    = 1'b0;
        timed_out   = 1'b0;
        in_beat     = (state_q == BEAT0) || (state_q == BEAT1);
        // the counter has seen TIMEOUT_CYCLES-1 idle cycles; this is the last
        timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    accept = 1'b1;
                    if (!ALLOW_MISALIGNED && two_beats) begin
                        reject  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = BEAT0;
                    end
                end
            end
            BEAT0, BEAT1: begin
                if (MemAck) begin
                    beat_ack = 1'b1;
                    state_d  = (state_q == BEAT0 && two_beats) ? BEAT1 : RESP;
                end else if (timeout_hit) begin
                    timed_out = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            req_write_q  <= 1'b0;
            req_strobe_q <= 3'b000;
            req_addr_q   <= 32'h0;
            req_wdata_q  <= 32'h0;
            wait_cnt     <= '0;
            merge_q      <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_be_q     <= 4'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            if (accept) begin
                req_write_q  <= ReqWrite;
                req_strobe_q <= ReqStrobe;
                req_addr_q   <= ReqAddr;
                req_wdata_q  <= ReqWData;
            end

            if (accept && !reject) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= ReqWrite;
                mem_addr_q  <= {ReqAddr[31:2], 2'b00};
                mem_be_q    <= be0;
                mem_wdata_q <= ReqWrite ? store_w0 : 32'h0;
                wait_cnt    <= '0;
            end else if (beat_ack && state_d == BEAT1) begin
                merge_q     <= MemRData & lane_mask(be0);
                mem_addr_q  <= {req_addr_q[31:2] + 30'd1, 2'b00};
                mem_be_q    <= be1;
                mem_wdata_q <= req_write_q ? store_w1 : 32'h0;
                wait_cnt    <= '0;
            end else if (beat_ack || timed_out) begin
                // a completed beat0 store is left in memory on a beat1 timeout
                mem_req_q   <= 1'b0;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= 32'h0;
                mem_be_q    <= 4'h0;
                mem_wdata_q <= 32'h0;
                wait_cnt    <= '0;
            end else if (in_beat) begin
                wait_cnt    <= wait_cnt + 1'b1;
            end

            if (state_d == RESP) begin
                resp_err_q   <= reject || timed_out;
                resp_rdata_q <= (beat_ack && !req_write_q) ? load_data : 32'h0;
            end
        end
    end

    assign ReqReady  = (state_q == IDLE);
    assign RespValid = (state_q == RESP);
    assign RespErr   = RespValid & resp_err_q;
    assign RespRData = RespValid ? resp_rdata_q : 32'h0;
    assign MemReq    = mem_req_q;
    assign MemWe     = mem_we_q;
    assign MemAddr   = mem_addr_q;
    assign MemByteEn = mem_be_q;
    assign MemWData  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit. A word-level memory
//                responder serves the bus; a byte-addressed reference model
//                predicts load data, final memory contents and latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam logic [31:0] BASE = 32'h100;   // modelled window 0x100..0x2FF

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic        ReqValid, ReqReady, ReqWrite;
    logic [2:0]  ReqStrobe;
    logic [31:0] ReqAddr, ReqWData;
    logic        RespValid, RespErr;
    logic [31:0] RespRData;
    logic        MemReq, MemAck, MemWe;
    logic [31:0] MemAddr, MemWData, MemRData;
    logic [3:0]  MemByteEn;

    logic        nm_valid, nm_ready, nm_write, nm_resp_valid, nm_resp_err;
    logic [2:0]  nm_strobe;
    logic [31:0] nm_addr, nm_wdata, nm_rdata, nm_mem_addr, nm_mem_wdata;
    logic        nm_mem_req, nm_mem_we;
    logic [3:0]  nm_mem_be;
    logic        nm_mem_ack = 1'b0;
    logic [31:0] nm_mem_rdata = 32'h0;

    load_store_unit #(.TIMEOUT_CYCLES(16), .ALLOW_MISALIGNED(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqStrobe(ReqStrobe), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .RespValid(RespValid), .RespRData(RespRData), .RespErr(RespErr),
        .MemReq(MemReq), .MemAck(MemAck), .MemWe(MemWe), .MemAddr(MemAddr),
        .MemByteEn(MemByteEn), .MemWData(MemWData), .MemRData(MemRData)
    );

    load_store_unit #(.TIMEOUT_CYCLES(16), .ALLOW_MISALIGNED(1'b0)) dut_nm (
        .CLK(CLK), .RST(RST),
        .ReqValid(nm_valid), .ReqReady(nm_ready), .ReqWrite(nm_write),
        .ReqStrobe(nm_strobe), .ReqAddr(nm_addr), .ReqWData(nm_wdata),
        .RespValid(nm_resp_valid), .RespRData(nm_rdata), .RespErr(nm_resp_err),
        .MemReq(nm_mem_req), .MemAck(nm_mem_ack), .MemWe(nm_mem_we), .MemAddr(nm_mem_addr),
        .MemByteEn(nm_mem_be), .MemWData(nm_mem_wdata), .MemRData(nm_mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_words [128];
    logic [7:0]  ref_bytes [512];
    logic [31:0] beat_addr [2];
    logic [31:0] beat_be   [2];
    logic [31:0] beat_wd   [2];
    int          n_beats, lat, req_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] stb);
        case (stb)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Byte-level reference: the lowest address is the most significant byte.
    function automatic logic [31:0] model_access(input logic wr, input logic [2:0] stb,
                                                 input logic [31:0] addr, input logic [31:0] wd);
        int n = size_of(stb);
        int b = int'(addr - BASE);
        logic [31:0] v = 32'h0;
        if (wr) begin
            for (int i = 0; i < n; i++) ref_bytes[b + i] = wd[8*(n-1-i) +: 8];
            return 32'h0;
        end
        for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, ref_bytes[b + i]};
        if (n < 4 && !stb[2] && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        return v;
    endfunction

    task automatic poke(input logic [31:0] addr, input logic [31:0] word);
        int b = int'(addr - BASE);
        mem_words[b / 4] = word;
        for (int i = 0; i < 4; i++) ref_bytes[b + i] = word[31-8*i -: 8];
    endtask

    // Issue one request (caller is at a negedge) and act as the memory,
    // holding off each beat's acknowledge for 'waits' cycles.
    task automatic access(input logic wr, input logic [2:0] stb, input logic [31:0] addr,
                          input logic [31:0] wd, input int waits,
                          output logic [31:0] rdata, output logic err);
        int cyc, w, idx;
        bit done, in_beat;
        logic [31:0] a0, wd0, be0;
        logic we0;
        check("ready_idle", {31'b0, ReqReady}, 1);
        ReqValid = 1'b1; ReqWrite = wr; ReqStrobe = stb; ReqAddr = addr; ReqWData = wd;
        @(posedge CLK); @(negedge CLK);
        ReqValid = 1'b0; ReqWData = $urandom; ReqAddr = $urandom;
        cyc = 1; done = 0; in_beat = 0; w = 0; n_beats = 0; req_cycles = 0;
        rdata = 32'h0; err = 1'b0; lat = -1;
        a0 = 0; wd0 = 0; be0 = 0; we0 = 0;
        while (!done && cyc < 200) begin
            check("ready_busy", {31'b0, ReqReady}, 0);
            if (RespValid) begin
                rdata = RespRData; err = RespErr; lat = cyc; done = 1;
            end else begin
                if (MemReq) begin
                    req_cycles++;
                    if (!in_beat) begin
                        in_beat = 1; w = 0;
                        a0 = MemAddr; wd0 = MemWData; be0 = {28'h0, MemByteEn}; we0 = MemWe;
                        check("addr_low_bits", {30'h0, MemAddr[1:0]}, 0);
                        check("mem_we", {31'b0, MemWe}, {31'b0, wr});
                        if (n_beats < 2) begin
                            beat_addr[n_beats] = MemAddr; beat_be[n_beats] = be0; beat_wd[n_beats] = MemWData;
                        end
                        n_beats++;
                    end else begin
                        check("hold_addr", MemAddr, a0);
                        check("hold_be", {28'h0, MemByteEn}, be0);
                        check("hold_wdata", MemWData, wd0);
                        check("hold_we", {31'b0, MemWe}, {31'b0, we0});
                    end
                    if (w < waits) begin
                        MemAck = 1'b0; MemRData = $urandom; w++;
                    end else begin
                        MemAck = 1'b1; in_beat = 0;
                        if (MemAddr >= BASE && MemAddr < BASE + 32'd512) begin
                            idx = int'((MemAddr - BASE) >> 2);
                            if (MemWe)
                                for (int k = 0; k < 4; k++)
                                    if (MemByteEn[3-k]) mem_words[idx][31-8*k -: 8] = MemWData[31-8*k -: 8];
                            MemRData = mem_words[idx];
                        end else begin
                            MemRData = 32'hDEAD_BEEF;
                        end
                    end
                end
                @(posedge CLK); @(negedge CLK);
                MemAck = 1'b0;
                cyc++;
            end
        end
        if (!done) check("resp_seen", 0, 1);
        @(posedge CLK); @(negedge CLK);
        check("ready_after", {31'b0, ReqReady}, 1);
        check("resp_pulse", {31'b0, RespValid}, 0);
        check("rdata_clear", RespRData, 0);
    endtask

    task automatic txn(input logic wr, input logic [2:0] stb, input logic [31:0] addr,
                       input logic [31:0] wd, input int waits, output logic [31:0] got);
        logic [31:0] exp;
        logic err;
        int beats;
        beats = (int'(addr[1:0]) + size_of(stb) > 4) ? 2 : 1;
        exp = model_access(wr, stb, addr, wd);
        access(wr, stb, addr, wd, waits, got, err);
        check("rdata", got, exp);
        check("err", {31'b0, err}, 0);
        check("beats", n_beats, beats);
        check("latency", lat, 1 + beats * (waits + 1));
    endtask

    initial begin
        logic [31:0] got;
        logic err;
        RST = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqStrobe = 3'b0;
        ReqAddr = 32'h0; ReqWData = 32'h0; MemAck = 1'b0; MemRData = 32'h0;
        nm_valid = 1'b0; nm_write = 1'b0; nm_strobe = 3'b0; nm_addr = 32'h0; nm_wdata = 32'h0;
        for (int i = 0; i < 128; i++) poke(BASE + 32'(4 * i), $urandom);

        repeat (3) @(negedge CLK);
        check("rst_ready", {31'b0, ReqReady}, 1);
        check("rst_resp_valid", {31'b0, RespValid}, 0);
        check("rst_resp_err", {31'b0, RespErr}, 0);
        check("rst_resp_rdata", RespRData, 0);
        check("rst_mem_req", {31'b0, MemReq}, 0);
        check("rst_mem_we", {31'b0, MemWe}, 0);
        check("rst_mem_addr", MemAddr, 0);
        check("rst_mem_be", {28'h0, MemByteEn}, 0);
        check("rst_mem_wdata", MemWData, 0);
        RST = 1'b1;
        @(negedge CLK);

        // aligned sw
        txn(1'b1, 3'b010, 32'h100, 32'h1122_3344, 0, got);
        check("sw_addr", beat_addr[0], 32'h100);
        check("sw_be", beat_be[0], 32'hF);
        check("sw_wdata", beat_wd[0], 32'h1122_3344);
        check("sw_mem", mem_words[0], 32'h1122_3344);

        // single-lane loads
        poke(32'h104, 32'hA1B2_C3D4);
        txn(1'b0, 3'b000, 32'h106, 32'h0, 0, got);
        check("lb_value", got, 32'hFFFF_FFC3);
        check("lb_be", beat_be[0], 32'h2);
        txn(1'b0, 3'b100, 32'h106, 32'h0, 1, got);
        check("lbu_value", got, 32'h0000_00C3);
        check("lbu_be", beat_be[0], 32'h2);

        // split sh
        txn(1'b1, 3'b001, 32'h103, 32'h0000_BEEF, 0, got);
        check("sh_b0_addr", beat_addr[0], 32'h100);
        check("sh_b0_be", beat_be[0], 32'h1);
        check("sh_b0_wdata", beat_wd[0], 32'h0000_00BE);
        check("sh_b1_addr", beat_addr[1], 32'h104);
        check("sh_b1_be", beat_be[1], 32'h8);
        check("sh_b1_wdata", beat_wd[1], 32'hEF00_0000);

        // split lw with two wait cycles per beat
        poke(32'h200, 32'h0102_0304);
        poke(32'h204, 32'h0506_0708);
        txn(1'b0, 3'b010, 32'h202, 32'h0, 2, got);
        check("lw_split_value", got, 32'h0304_0506);
        check("lw_split_latency", lat, 7);

        // timeout with no acknowledge
        access(1'b0, 3'b010, 32'h108, 32'h0, 100000, got, err);
        check("to_err", {31'b0, err}, 1);
        check("to_rdata", got, 0);
        check("to_req_cycles", req_cycles, 16);
        check("to_latency", lat, 17);

        // word-address wrap on the second beat
        access(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_1234, 0, got, err);
        check("wrap_b0_addr", beat_addr[0], 32'hFFFF_FFFC);
        check("wrap_b1_addr", beat_addr[1], 32'h0000_0000);
        check("wrap_b1_wdata", beat_wd[1], 32'h3400_0000);
        check("wrap_err", {31'b0, err}, 0);

        // randomized traffic against the byte model
        for (int t = 0; t < 300; t++) begin
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                BASE + 32'($urandom_range(0, 507)), $urandom, $urandom_range(0, 3), got);
        end
        for (int i = 0; i < 128; i++)
            check("mem_final", mem_words[i],
                  {ref_bytes[4*i], ref_bytes[4*i+1], ref_bytes[4*i+2], ref_bytes[4*i+3]});

        // misaligned access rejected when splitting is disabled
        nm_valid = 1'b1; nm_write = 1'b0; nm_strobe = 3'b010; nm_addr = 32'h1;
        @(posedge CLK); @(negedge CLK);
        nm_valid = 1'b0;
        check("nm_resp_valid", {31'b0, nm_resp_valid}, 1);
        check("nm_resp_err", {31'b0, nm_resp_err}, 1);
        check("nm_rdata", nm_rdata, 0);
        check("nm_no_req", {31'b0, nm_mem_req}, 0);
        @(negedge CLK);
        check("nm_ready_after", {31'b0, nm_ready}, 1);
        check("nm_no_req2", {31'b0, nm_mem_req}, 0);
        check("nm_mem_idle", nm_mem_addr | nm_mem_wdata | {28'h0, nm_mem_be} | {31'b0, nm_mem_we}, 0);

        // asynchronous reset while in the second beat
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqStrobe = 3'b010; ReqAddr = 32'h102;
        @(posedge CLK); @(negedge CLK);
        ReqValid = 1'b0; MemAck = 1'b1; MemRData = 32'h0;
        @(posedge CLK); @(negedge CLK);
        MemAck = 1'b0;
        check("rb_in_beat1", {31'b0, MemReq}, 1);
        check("rb_beat1_addr", MemAddr, 32'h104);
        #1 RST = 1'b0;
        #1;
        check("rb_mem_req", {31'b0, MemReq}, 0);
        check("rb_mem_addr", MemAddr, 0);
        check("rb_mem_be", {28'h0, MemByteEn}, 0);
        check("rb_ready", {31'b0, ReqReady}, 1);
        check("rb_resp_valid", {31'b0, RespValid}, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("rb_no_resp", {31'b0, RespValid}, 0);
            check("rb_no_req", {31'b0, MemReq}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
